ts_client_arbiter: RTL and testbench
====================================

Name: ts_client_arbiter

Overview:
Shares one event_timestamper instance among N_CLI independent clients. The block allocates event IDs from a free pool and round-robin arbitrates client start and end requests onto the timestamper's single start/end channels. It also routes each completed output record back to the client that owns the ID. It sits between client logic (e.g. per-port UDP packet taps) and the timestamper, so clients never manage IDs themselves.

Parameters:
N_CLI, 4, number of client ports (power of 2, >=2); CLI_W = $clog2(N_CLI) is a localparam
ID_W, 4, timestamper ID width; pool depth DEPTH = 2**ID_W
TS_W, 64, timestamp width of the routed record

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cli_start_valid  in  N_CLI  per-client start request
cli_start_ready  out  N_CLI  start accepted; at most one bit high per cycle
cli_start_id  out  ID_W  allocated ID; meaningful in a start handshake cycle only
cli_end_valid  in  N_CLI  per-client end request
cli_end_ready  out  N_CLI  end consumed (forwarded or dropped); at most one bit high
cli_end_id  in  N_CLI*ID_W  per-client ID to end; client k uses bits [k*ID_W +: ID_W]
ts_start_valid / ts_start_ready / ts_start_id  out/in/out  1/1/ID_W  timestamper start channel
ts_end_valid / ts_end_ready / ts_end_id  out/in/out  1/1/ID_W  timestamper end channel
ts_out_valid / ts_out_ready  in/out  1/1  timestamper record channel
ts_out_id  in  ID_W  record ID
ts_out_ts  in  TS_W  record duration (end - start)
cli_rec_valid  out  N_CLI  record valid, one-hot to the owner client
cli_rec_ready  in  N_CLI  per-client record ready
cli_rec_id  out  ID_W  shared record ID bus; equals ts_out_id
cli_rec_ts  out  TS_W  shared record duration bus; equals ts_out_ts
inflight_cnt  out  ID_W+1  number of allocated IDs
err_bad_end  out  1  one-cycle pulse: an end request was dropped
err_client  out  CLI_W  client that issued the dropped end; holds until the next error

Behaviour:
- State:
  - free_q[DEPTH]: bitmap of free IDs. Reset value is all ones.
  - owner_q[DEPTH]: CLI_W bits per ID, the owning client.
  - start_ptr_q, end_ptr_q: round-robin pointers. Reset value 0.
  - inflight_q: allocated-ID counter. Reset value 0.
  - err_bad_end: reset 0. err_client: reset 0.
- Start path (fully combinational, zero added latency):
  - Grant = first requesting client at or after start_ptr_q, searching cyclically.
  - ts_start_valid = |cli_start_valid && |free_q.
  - ts_start_id = lowest-index set bit of free_q. cli_start_id = ts_start_id.
  - cli_start_ready[g] = ts_start_ready && ts_start_valid && (g == grant).
  - ts_start_valid must not depend on ts_start_ready.
  - On fire: clear free_q[id], set owner_q[id] = grant, set start_ptr_q = grant+1 (mod N_CLI).
  - With no fire, start_ptr_q holds.
- Pool empty: ts_start_valid = 0 and all cli_start_ready = 0. Requests wait; no error is raised.
- End path:
  - Grant = first requesting client at or after end_ptr_q, searching cyclically.
  - legal = !free_q[id] && owner_q[id] == grant.
  - If legal: ts_end_valid = 1, ts_end_id = id, cli_end_ready[grant] = ts_end_ready.
  - If illegal: ts_end_valid = 0 and cli_end_ready[grant] = 1 that cycle (request dropped). err_bad_end pulses high on the next cycle; err_client = grant is registered with it.
  - On any end handshake: end_ptr_q = grant+1.
  - An end handshake does not free the ID. The ID stays owned until its record is delivered, so routing remains valid.
- Record path (combinational):
  - o = owner_q[ts_out_id].
  - cli_rec_valid = ts_out_valid ? onehot(o) : 0.
  - ts_out_ready = cli_rec_ready[o].
  - On handshake: set free_q[ts_out_id] = 1.
- Record for a free ID: this is a protocol violation. It is delivered anyway, using the stale owner_q value; this case is flagged only by assertion.
- inflight_cnt: +1 on start fire, -1 on record handshake. Both in the same cycle leaves it unchanged. It always equals DEPTH - popcount(free_q) (assertion).
- Same-cycle free and allocate: allocation uses the pre-edge free_q. A just-freed ID is reusable from the next cycle.
- The timestamper's same-ID start/end hazard cannot occur, because issued IDs are always free and ended IDs are always owned. Assert ts_start_id != ts_end_id whenever both valids are high.
- Reset mid-operation:
  - All state returns to its reset value; in-flight events and pending records are discarded.
  - The timestamper must share rst.
  - All valid/ready outputs are 0 during reset, except ts_out_ready, which follows its combinational definition.

Decomposition:
- Package ts_pkg holds: ID_W/TS_W defaults, typedefs id_t, ts_t, cli_idx_t, and a function onehot().
- Sub-module rr_arbiter #(N): inputs req[N], ptr; output grant index and any-grant flag. It is instantiated twice, once for start and once for end.
- Free-pool lowest-set-bit encoder is an inline function.

Test Plan:
1. After reset, client 2 starts with ts_start_ready=1 -> cli_start_id=0, owner_q[0]=2, inflight_cnt=1, start_ptr_q=3.
2. Clients 0, 1 and 3 hold start valid together, continuing from test 1 -> grants in order 3, 0, 1 with IDs 1, 2, 3; inflight_cnt=4.
3. Allocate all 16 IDs, then raise a 17th start -> cli_start_ready=0 and ts_start_valid=0. Deliver the record for ID 5 -> the next cycle's start receives ID 5.
4. Client 1 ends ID 0, which client 2 owns -> cli_end_ready[1]=1 and ts_end_valid=0; next cycle err_bad_end=1 and err_client=1.
5. Record for ID 2 (owner 0) with cli_rec_ready[0]=0 for 3 cycles -> cli_rec_valid=4'b0001 and ts_out_ready=0 held. Then ready=1 -> handshake, free_q[2]=1, inflight_cnt decrements.
6. Assert rst with 5 IDs in flight and one record pending -> free_q all ones, inflight_cnt=0, cli_rec_valid=0; the first start after reset gets ID 0.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared definitions for the timestamper client arbiter.
//   ID_W_DEF / TS_W_DEF / N_CLI_DEF : default widths and client count
//   id_t, ts_t, cli_idx_t           : convenience types at the default sizes
//   onehot()                        : index -> one-hot vector (up to MAX_CLI bits)
package ts_pkg;

    localparam int ID_W_DEF  = 4;
    localparam int TS_W_DEF  = 64;
    localparam int N_CLI_DEF = 4;
    localparam int CLI_W_DEF = $clog2(N_CLI_DEF);
    localparam int MAX_CLI   = 32;

    typedef logic [ID_W_DEF-1:0]  id_t;
    typedef logic [TS_W_DEF-1:0]  ts_t;
    typedef logic [CLI_W_DEF-1:0] cli_idx_t;

    function automatic logic [MAX_CLI-1:0] onehot(input logic [4:0] idx);
        return MAX_CLI'(1) << idx;
    endfunction

endpackage

// File: rtl/ts_client_arbiter_if.sv
// Bundle of every client-side and timestamper-side signal of the arbiter.
//   slave  : arbiter view (client requests and timestamper responses in)
//   master : environment view (clients plus timestamper)
interface ts_client_arbiter_if #(
    parameter int N_CLI = ts_pkg::N_CLI_DEF,
    parameter int ID_W  = ts_pkg::ID_W_DEF,
    parameter int TS_W  = ts_pkg::TS_W_DEF
);
    logic [N_CLI-1:0]         cli_start_valid;
    logic [N_CLI-1:0]         cli_start_ready;
    logic [ID_W-1:0]          cli_start_id;
    logic [N_CLI-1:0]         cli_end_valid;
    logic [N_CLI-1:0]         cli_end_ready;
    logic [N_CLI*ID_W-1:0]    cli_end_id;
    logic                     ts_start_valid;
    logic                     ts_start_ready;
    logic [ID_W-1:0]          ts_start_id;
    logic                     ts_end_valid;
    logic                     ts_end_ready;
    logic [ID_W-1:0]          ts_end_id;
    logic                     ts_out_valid;
    logic                     ts_out_ready;
    logic [ID_W-1:0]          ts_out_id;
    logic [TS_W-1:0]          ts_out_ts;
    logic [N_CLI-1:0]         cli_rec_valid;
    logic [N_CLI-1:0]         cli_rec_ready;
    logic [ID_W-1:0]          cli_rec_id;
    logic [TS_W-1:0]          cli_rec_ts;
    logic [ID_W:0]            inflight_cnt;
    logic                     err_bad_end;
    logic [$clog2(N_CLI)-1:0] err_client;

    modport slave (
        input  cli_start_valid, cli_end_valid, cli_end_id, ts_start_ready,
               ts_end_ready, ts_out_valid, ts_out_id, ts_out_ts, cli_rec_ready,
        output cli_start_ready, cli_start_id, cli_end_ready, ts_start_valid,
               ts_start_id, ts_end_valid, ts_end_id, ts_out_ready,
               cli_rec_valid, cli_rec_id, cli_rec_ts, inflight_cnt,
               err_bad_end, err_client
    );

    modport master (
        output cli_start_valid, cli_end_valid, cli_end_id, ts_start_ready,
               ts_end_ready, ts_out_valid, ts_out_id, ts_out_ts, cli_rec_ready,
        input  cli_start_ready, cli_start_id, cli_end_ready, ts_start_valid,
               ts_start_id, ts_end_valid, ts_end_id, ts_out_ready,
               cli_rec_valid, cli_rec_id, cli_rec_ts, inflight_cnt,
               err_bad_end, err_client
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : first requester at or after ptr, searching cyclically
//   any_grant : at least one request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_grant
);
    localparam int W = $clog2(N);

    // Walk offsets from farthest to nearest so the nearest requester wins;
    // N is a power of two, so the W-bit sum wraps cyclically for free.
    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[W'(ptr + W'(i))]) grant = W'(ptr + W'(i));
        end
    end

    assign any_grant = |req;
endmodule

// File: rtl/ts_client_arbiter.sv
// Shares one event timestamper among N_CLI clients: allocates IDs from a free
// pool, round-robins start and end requests onto the timestamper channels, and
// steers each finished record back to the client that owns its ID.
//   clk, rst : clock, synchronous active-high reset
//   bus      : client start/end/record channels, timestamper start/end/out
//              channels, inflight_cnt and the bad-end error report
module ts_client_arbiter
    import ts_pkg::*;
#(
    parameter int N_CLI = N_CLI_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    ts_client_arbiter_if.slave bus
);
    localparam int CLI_W = $clog2(N_CLI);
    localparam int DEPTH = 2 ** ID_W;

    logic [DEPTH-1:0] free_q;
    logic [CLI_W-1:0] owner_q [DEPTH];
    logic [CLI_W-1:0] start_ptr_q;
    logic [CLI_W-1:0] end_ptr_q;
    logic [ID_W:0]    inflight_q;
    logic             err_bad_end_q;
    logic [CLI_W-1:0] err_client_q;

    logic [CLI_W-1:0] start_grant, end_grant, rec_owner;
    logic             start_any, end_any;
    logic [ID_W-1:0]  start_id, end_id;
    logic             start_fire, end_legal, end_hs, bad_end, rec_hs;
    logic [TS_W-1:0]  rec_ts;

    function automatic logic [ID_W-1:0] lowest_free(input logic [DEPTH-1:0] f);
        lowest_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (f[i]) lowest_free = ID_W'(i);
        end
    endfunction

    rr_arbiter #(.N(N_CLI)) u_start_arb (
        .req       (bus.cli_start_valid),
        .ptr       (start_ptr_q),
        .grant     (start_grant),
        .any_grant (start_any)
    );

    rr_arbiter #(.N(N_CLI)) u_end_arb (
        .req       (bus.cli_end_valid),
        .ptr       (end_ptr_q),
        .grant     (end_grant),
        .any_grant (end_any)
    );

    // Start path: valid is independent of ts_start_ready.
    assign start_id            = lowest_free(free_q);
    assign bus.ts_start_valid  = !rst && start_any && (|free_q);
    assign bus.ts_start_id     = start_id;
    assign bus.cli_start_id    = start_id;
    assign start_fire          = bus.ts_start_valid && bus.ts_start_ready;
    assign bus.cli_start_ready = start_fire ? N_CLI'(onehot(5'(start_grant))) : '0;

    // End path: only the owner of an allocated ID may end it; anything else
    // is consumed here and reported instead of reaching the timestamper.
    assign end_id            = bus.cli_end_id[int'(end_grant) * ID_W +: ID_W];
    assign end_legal         = !free_q[end_id] && (owner_q[end_id] == end_grant);
    assign bus.ts_end_valid  = !rst && end_any && end_legal;
    assign bus.ts_end_id     = end_id;
    assign end_hs            = !rst && end_any && (!end_legal || bus.ts_end_ready);
    assign bad_end           = !rst && end_any && !end_legal;
    assign bus.cli_end_ready = end_hs ? N_CLI'(onehot(5'(end_grant))) : '0;

    // Record path: the ID stays owned until its record is delivered.
    assign rec_owner         = owner_q[bus.ts_out_id];
    assign bus.cli_rec_valid = (!rst && bus.ts_out_valid) ? N_CLI'(onehot(5'(rec_owner))) : '0;
    assign bus.ts_out_ready  = bus.cli_rec_ready[rec_owner];
    assign rec_hs            = !rst && bus.ts_out_valid && bus.ts_out_ready;
    assign bus.cli_rec_id    = bus.ts_out_id;
    assign rec_ts            = bus.ts_out_ts;
    assign bus.cli_rec_ts    = rec_ts;

    assign bus.inflight_cnt = inflight_q;
    assign bus.err_bad_end  = err_bad_end_q;
    assign bus.err_client   = err_client_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q        <= '1;
            start_ptr_q   <= '0;
            end_ptr_q     <= '0;
            inflight_q    <= '0;
            err_bad_end_q <= 1'b0;
            err_client_q  <= '0;
        end else begin
            // Allocation sees the pre-edge pool; a freed ID is reusable next cycle.
            free_q <= (free_q & ~(start_fire ? DEPTH'(1) << start_id : '0))
                    | (rec_hs ? DEPTH'(1) << bus.ts_out_id : '0);
            if (start_fire) start_ptr_q <= start_grant + 1'b1;
            if (end_hs)     end_ptr_q   <= end_grant + 1'b1;
            inflight_q    <= inflight_q + (ID_W+1)'(start_fire) - (ID_W+1)'(rec_hs);
            err_bad_end_q <= bad_end;
            if (bad_end) err_client_q <= end_grant;
        end
    end

    // Ownership is data: only meaningful while the matching free bit is clear.
    always_ff @(posedge clk) begin
        if (start_fire) owner_q[start_id] <= start_grant;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (inflight_q == (ID_W+1)'(DEPTH - $countones(free_q)));
            assert (!(bus.ts_out_valid && free_q[bus.ts_out_id]));
            assert (!(bus.ts_start_valid && bus.ts_end_valid &&
                      bus.ts_start_id == bus.ts_end_id));
        end
    end
endmodule

// File: tb/tb_ts_client_arbiter.sv
module tb_ts_client_arbiter;
    import ts_pkg::*;

    localparam int N     = 4;
    localparam int IW    = 4;
    localparam int TW    = 64;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ts_client_arbiter_if #(.N_CLI(N), .ID_W(IW), .TS_W(TW)) bus ();

    ts_client_arbiter #(.N_CLI(N), .ID_W(IW), .TS_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: pool as flags, owners as plain ints, queue of ended IDs
    // standing in for the timestamper's pending records.
    bit m_free  [DEPTH];
    int m_owner [DEPTH];
    bit m_ended [DEPTH];
    int m_sptr, m_eptr, m_infl, m_errc;
    bit m_err;
    int rq [$];

    // Per-cycle expectations carried from the check to the state update.
    bit e_fire, e_ev, e_ehs, e_bad, e_rhs, e_ter;
    int e_sid, e_sg, e_eg, e_eid, e_rid;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_free[i]  = 1'b1;
            m_ended[i] = 1'b0;
        end
        m_sptr = 0; m_eptr = 0; m_infl = 0; m_err = 0; m_errc = 0;
        rq.delete();
    endfunction

    task automatic eval_check();
        int sg, eg, fid, ro;
        bit e_sv, e_eleg;
        logic [N-1:0] exp_sr, exp_er, exp_rv;
        #1;
        sg  = rr(bus.cli_start_valid, m_sptr);
        fid = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (m_free[i]) fid = i;
        e_sv   = !rst && sg >= 0 && fid >= 0;
        e_fire = e_sv && bus.ts_start_ready;
        e_sg   = sg;
        e_sid  = fid;
        exp_sr = e_fire ? N'(1) << sg : '0;
        chk("ts_start_valid", bus.ts_start_valid, e_sv);
        chk("cli_start_ready", bus.cli_start_ready, exp_sr);
        if (e_sv) begin
            chk("ts_start_id", bus.ts_start_id, fid);
            chk("cli_start_id", bus.cli_start_id, fid);
        end

        eg   = rr(bus.cli_end_valid, m_eptr);
        e_eg = eg;
        if (eg >= 0) begin
            e_eid  = int'(bus.cli_end_id[eg*IW +: IW]);
            e_eleg = !m_free[e_eid] && m_owner[e_eid] == eg;
        end else begin
            e_eid  = 0;
            e_eleg = 0;
        end
        e_ter  = bus.ts_end_ready;
        e_ev   = !rst && eg >= 0 && e_eleg;
        e_ehs  = !rst && eg >= 0 && (!e_eleg || e_ter);
        e_bad  = !rst && eg >= 0 && !e_eleg;
        exp_er = e_ehs ? N'(1) << eg : '0;
        chk("ts_end_valid", bus.ts_end_valid, e_ev);
        chk("cli_end_ready", bus.cli_end_ready, exp_er);
        if (e_ev) chk("ts_end_id", bus.ts_end_id, e_eid);

        e_rid  = int'(bus.ts_out_id);
        ro     = m_owner[e_rid];
        exp_rv = (!rst && bus.ts_out_valid) ? N'(1) << ro : '0;
        chk("cli_rec_valid", bus.cli_rec_valid, exp_rv);
        e_rhs = 0;
        if (!rst && bus.ts_out_valid) begin
            chk("ts_out_ready", bus.ts_out_ready, bus.cli_rec_ready[ro]);
            chk("cli_rec_id", bus.cli_rec_id, bus.ts_out_id);
            chk("cli_rec_ts", bus.cli_rec_ts, bus.ts_out_ts);
            e_rhs = bus.cli_rec_ready[ro];
        end

        chk("inflight_cnt", bus.inflight_cnt, m_infl);
        chk("err_bad_end", bus.err_bad_end, m_err);
        chk("err_client", bus.err_client, m_errc);
    endtask

    function automatic void model_update();
        if (rst) begin
            model_reset();
            return;
        end
        if (e_fire) begin
            m_free[e_sid]  = 1'b0;
            m_owner[e_sid] = e_sg;
            m_sptr = (e_sg + 1) % N;
            m_infl++;
        end
        if (e_ehs) begin
            m_eptr = (e_eg + 1) % N;
            if (e_ev && e_ter && !m_ended[e_eid]) begin
                rq.push_back(e_eid);
                m_ended[e_eid] = 1'b1;
            end
        end
        m_err = e_bad;
        if (e_bad) m_errc = e_eg;
        if (e_rhs) begin
            m_free[e_rid]  = 1'b1;
            m_ended[e_rid] = 1'b0;
            m_infl--;
            if (rq.size() > 0 && rq[0] == e_rid) void'(rq.pop_front());
        end
    endfunction

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cli_start_valid = '0;
        bus.cli_end_valid   = '0;
        bus.cli_end_id      = '0;
        bus.ts_start_ready  = 1'b0;
        bus.ts_end_ready    = 1'b0;
        bus.ts_out_valid    = 1'b0;
        bus.ts_out_id       = '0;
        bus.ts_out_ts       = '0;
        bus.cli_rec_ready   = '0;
    endtask

    task automatic rand_cycle();
        logic [N*IW-1:0] ce;
        int own [$];
        int id;
        ce  = '0;
        rst = ($urandom_range(0, 799) == 0);
        bus.cli_start_valid = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 15)) : '0;
        bus.ts_start_ready  = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) begin
            own.delete();
            for (int i = 0; i < DEPTH; i++) if (!m_free[i] && m_owner[i] == k) own.push_back(i);
            if (own.size() > 0 && $urandom_range(0, 3) != 0)
                id = own[$urandom_range(0, own.size() - 1)];
            else
                id = $urandom_range(0, DEPTH - 1);
            ce[k*IW +: IW] = IW'(id);
        end
        bus.cli_end_id    = ce;
        bus.cli_end_valid = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
        bus.ts_end_ready  = ($urandom_range(0, 2) != 0);
        if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.ts_out_valid = 1'b1;
            bus.ts_out_id    = IW'(rq[0]);
        end else begin
            bus.ts_out_valid = 1'b0;
            bus.ts_out_id    = IW'($urandom_range(0, DEPTH - 1));
        end
        bus.ts_out_ts     = {$urandom, $urandom};
        bus.cli_rec_ready = N'($urandom_range(0, 15));
        eval_check();
        advance();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        eval_check();
        chk("rst_inflight", bus.inflight_cnt, 0);
        chk("rst_err", bus.err_bad_end, 0);
        chk("rst_start_valid", bus.ts_start_valid, 0);
        advance();

        // 1: first start after reset
        rst = 1'b0;
        bus.cli_start_valid = 4'b0100;
        bus.ts_start_ready  = 1'b1;
        eval_check();
        chk("t1_id", bus.cli_start_id, 0);
        chk("t1_ready", bus.cli_start_ready, 4'b0100);
        advance();

        // 2: round robin continues from client 3
        bus.cli_start_valid = 4'b1011;
        eval_check();
        chk("t2a_ready", bus.cli_start_ready, 4'b1000);
        chk("t2a_id", bus.cli_start_id, 1);
        advance();
        bus.cli_start_valid = 4'b0011;
        eval_check();
        chk("t2b_ready", bus.cli_start_ready, 4'b0001);
        chk("t2b_id", bus.cli_start_id, 2);
        advance();
        bus.cli_start_valid = 4'b0010;
        eval_check();
        chk("t2c_ready", bus.cli_start_ready, 4'b0010);
        chk("t2c_id", bus.cli_start_id, 3);
        advance();
        bus.cli_start_valid = '0;
        eval_check();
        chk("t2_inflight", bus.inflight_cnt, 4);
        advance();

        // 3: exhaust the pool, then free ID 5 and reuse it
        bus.cli_start_valid = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            eval_check();
            advance();
        end
        eval_check();
        chk("t3_full_valid", bus.ts_start_valid, 0);
        chk("t3_full_ready", bus.cli_start_ready, 0);
        chk("t3_full_cnt", bus.inflight_cnt, 16);
        advance();
        bus.ts_out_valid  = 1'b1;
        bus.ts_out_id     = 4'd5;
        bus.ts_out_ts     = 64'h0000_1234_5678_9abc;
        bus.cli_rec_ready = 4'b1111;
        eval_check();
        chk("t3_same_cycle_valid", bus.ts_start_valid, 0);
        chk("t3_rec_valid", bus.cli_rec_valid, 4'b0001);
        advance();
        bus.ts_out_valid = 1'b0;
        eval_check();
        chk("t3_reuse_valid", bus.ts_start_valid, 1);
        chk("t3_reuse_id", bus.cli_start_id, 5);
        advance();
        bus.cli_start_valid = '0;

        // 4: illegal end by a non-owner, then a legal end by the owner
        bus.cli_end_valid = 4'b0010;
        bus.cli_end_id    = '0;
        bus.ts_end_ready  = 1'b1;
        eval_check();
        chk("t4_end_ready", bus.cli_end_ready, 4'b0010);
        chk("t4_ts_end_valid", bus.ts_end_valid, 0);
        advance();
        bus.cli_end_valid = '0;
        eval_check();
        chk("t4_err", bus.err_bad_end, 1);
        chk("t4_err_client", bus.err_client, 1);
        advance();
        eval_check();
        chk("t4_err_pulse", bus.err_bad_end, 0);
        chk("t4_err_hold", bus.err_client, 1);
        bus.cli_end_valid = 4'b0100;
        bus.ts_end_ready  = 1'b0;
        eval_check();
        chk("t4_legal_valid", bus.ts_end_valid, 1);
        chk("t4_legal_wait", bus.cli_end_ready, 0);
        advance();
        bus.ts_end_ready = 1'b1;
        eval_check();
        chk("t4_legal_ready", bus.cli_end_ready, 4'b0100);
        chk("t4_legal_id", bus.ts_end_id, 0);
        advance();
        bus.cli_end_valid = '0;

        // 5: record back-pressure for ID 2, owned by client 0
        bus.ts_out_valid  = 1'b1;
        bus.ts_out_id     = 4'd2;
        bus.ts_out_ts     = 64'd777;
        bus.cli_rec_ready = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            eval_check();
            chk("t5_rec_valid", bus.cli_rec_valid, 4'b0001);
            chk("t5_stall", bus.ts_out_ready, 0);
            advance();
        end
        bus.cli_rec_ready = 4'b0001;
        eval_check();
        chk("t5_ready", bus.ts_out_ready, 1);
        advance();
        bus.ts_out_valid    = 1'b0;
        bus.cli_start_valid = 4'b1000;
        eval_check();
        chk("t5_cnt", bus.inflight_cnt, 15);
        chk("t5_freed_id", bus.cli_start_id, 2);
        advance();
        bus.cli_start_valid = '0;

        // 6: reset with 5 IDs in flight and a record pending
        rst = 1'b1;
        eval_check();
        advance();
        rst = 1'b0;
        bus.cli_start_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            eval_check();
            advance();
        end
        bus.cli_start_valid = '0;
        bus.ts_out_valid    = 1'b1;
        bus.ts_out_id       = 4'd1;
        bus.cli_rec_ready   = '0;
        eval_check();
        chk("t6_pending", bus.cli_rec_valid, 4'b0001);
        chk("t6_cnt5", bus.inflight_cnt, 5);
        advance();
        rst = 1'b1;
        eval_check();
        chk("t6_rst_rec_valid", bus.cli_rec_valid, 0);
        advance();
        rst = 1'b0;
        bus.ts_out_valid    = 1'b0;
        bus.cli_start_valid = 4'b0100;
        eval_check();
        chk("t6_cnt0", bus.inflight_cnt, 0);
        chk("t6_first_id", bus.cli_start_id, 0);
        chk("t6_first_ready", bus.cli_start_ready, 4'b0100);
        advance();

        // Randomised traffic against the reference model
        idle_inputs();
        for (int c = 0; c < 3000; c++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
